// File: rtl/axi_lite_write_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : axi_lite_write_arbiter
// Brief    : Two-requester round-robin arbiter feeding a single AXI-Lite writer.
// Revision : 1.0
// =============================================================================
module axi_lite_write_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        REQ0_VALID,
  input  logic [31:0] REQ0_ADDR,
  input  logic [31:0] REQ0_DATA,
  output logic        REQ0_READY,
  output logic        REQ0_DONE,
  input  logic        REQ1_VALID,
  input  logic [31:0] REQ1_ADDR,
  input  logic [31:0] REQ1_DATA,
  output logic        REQ1_READY,
  output logic        REQ1_DONE,
  output logic        W_Start,
  output logic [31:0] Write_to,
  output logic [31:0] W_Data,
  input  logic        Writer_Run,
  output logic        GRANT,
  output logic        BUSY,
  output logic        TIMEOUT_ERR,
  input  logic        ERR_CLR
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_RUN  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Last wait cycle index: the timeout fires in the TIMEOUT_CYCLES-th wait cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        winner;
  logic        finish;
  logic        timeout;

  // Single requester wins outright; on a tie the one not granted last wins.
  assign winner = REQ0_VALID ? (REQ1_VALID ? ~grant_q : 1'b0) : 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    finish     = 1'b0;
    timeout    = 1'b0;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    W_Start    = 1'b0;
    case (state_q)
      IDLE: begin
        REQ0_READY = REQ0_VALID && !winner;
        REQ1_READY = REQ1_VALID && winner;
        if (REQ0_VALID || REQ1_VALID) begin
          grant_d = winner;
          addr_d  = winner ? REQ1_ADDR : REQ0_ADDR;
          data_d  = winner ? REQ1_DATA : REQ0_DATA;
          cnt_d   = 8'd0;
          state_d = START;
        end
      end
      START: begin
        W_Start = 1'b1;
        state_d = WAIT_RUN;
      end
      WAIT_RUN: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (Writer_Run) begin
          state_d = WAIT_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          timeout = 1'b1;
        end
      end
      WAIT_DONE: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // A falling Writer_Run takes priority over a coincident timeout.
        if (!Writer_Run) begin
          finish = 1'b1;
        end else if (cnt_q >= CNT_LAST) begin
          timeout = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (finish || timeout) begin
      state_d = IDLE;
      done0_d = ~grant_q;
      done1_d = grant_q;
    end
    err_d = timeout ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign Write_to    = addr_q;
  assign W_Data      = data_q;
  assign GRANT       = grant_q;
  assign BUSY        = (state_q != IDLE);
  assign TIMEOUT_ERR = err_q;
  assign REQ0_DONE   = done0_q;
  assign REQ1_DONE   = done1_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_write_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_axi_lite_write_arbiter
// Brief    : Directed scoreboard bench for axi_lite_write_arbiter.
// Revision : 1.0
// =============================================================================
module tb_axi_lite_write_arbiter;

  localparam int TO = 8;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        REQ0_VALID = 1'b0;
  logic [31:0] REQ0_ADDR = 32'd0;
  logic [31:0] REQ0_DATA = 32'd0;
  logic        REQ0_READY;
  logic        REQ0_DONE;
  logic        REQ1_VALID = 1'b0;
  logic [31:0] REQ1_ADDR = 32'd0;
  logic [31:0] REQ1_DATA = 32'd0;
  logic        REQ1_READY;
  logic        REQ1_DONE;
  logic        W_Start;
  logic [31:0] Write_to;
  logic [31:0] W_Data;
  logic        Writer_Run = 1'b0;
  logic        GRANT;
  logic        BUSY;
  logic        TIMEOUT_ERR;
  logic        ERR_CLR = 1'b0;

  typedef struct {
    logic        g;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  logic done_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int n_dones  = 0;
  int run_len  = 5;
  int run_left = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_write_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA),
    .REQ0_READY(REQ0_READY), .REQ0_DONE(REQ0_DONE),
    .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA),
    .REQ1_READY(REQ1_READY), .REQ1_DONE(REQ1_DONE),
    .W_Start(W_Start), .Write_to(Write_to), .W_Data(W_Data),
    .Writer_Run(Writer_Run), .GRANT(GRANT), .BUSY(BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR), .ERR_CLR(ERR_CLR)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic g, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.g = g;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Writer model: Run rises the cycle after Start and stays high run_len cycles.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      Writer_Run = 1'b0;
      run_left   = 0;
    end else begin
      Writer_Run = (run_left > 0);
      if (run_left > 0) run_left--;
      if (W_Start) run_left = run_len;
    end
  end

  always @(negedge ACLK) begin
    #1;
    if (W_Start) begin
      n_starts++;
      check1("start_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check32("start_addr", Write_to, e.a);
        check32("start_data", W_Data, e.d);
        check1("start_grant", GRANT, e.g);
        done_q.push_back(e.g);
      end
    end
    if (REQ0_DONE || REQ1_DONE) begin
      n_dones++;
      check1("done_onehot", REQ0_DONE && REQ1_DONE, 1'b0);
      check1("done_idle", BUSY, 1'b0);
      check1("done_expected", done_q.size() > 0, 1'b1);
      if (done_q.size() > 0) check1("done_index", REQ1_DONE, done_q.pop_front());
    end
  end

  task automatic wait_ready(output int who);
    who = -1;
    for (int i = 0; i < 100 && who < 0; i++) begin
      #1;
      if (REQ0_READY || REQ1_READY) begin
        check1("ready_onehot", REQ0_READY && REQ1_READY, 1'b0);
        who = REQ0_READY ? 0 : 1;
      end else begin
        @(negedge ACLK);
      end
    end
    check1("ready_seen", who >= 0, 1'b1);
  endtask

  task automatic wait_idle();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      #1;
      if (!BUSY) seen = 1;
      else @(negedge ACLK);
    end
    check1("idle_reached", seen, 1'b1);
  endtask

  // Counts cycles from the acceptance cycle to the REQ0_DONE pulse.
  task automatic count_to_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ACLK);
      cyc++;
      if (cyc == 1) REQ0_VALID = 1'b0;
      #1;
      if (REQ0_DONE) break;
    end
  endtask

  task automatic reset_pulse();
    @(negedge ACLK);
    ARESETn = 1'b0;
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  initial begin
    int who, cyc, s0, d0;

    repeat (2) @(negedge ACLK);
    #1;
    check1("rst_busy", BUSY, 1'b0);
    check1("rst_grant", GRANT, 1'b1);
    check32("rst_write_to", Write_to, 32'd0);
    check32("rst_w_data", W_Data, 32'd0);
    check1("rst_w_start", W_Start, 1'b0);
    check1("rst_done0", REQ0_DONE, 1'b0);
    check1("rst_done1", REQ1_DONE, 1'b0);
    check1("rst_err", TIMEOUT_ERR, 1'b0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // Single request from requester 0.
    @(negedge ACLK);
    run_len = 5;
    s0 = n_starts; d0 = n_dones;
    REQ0_ADDR = 32'h0000_0010; REQ0_DATA = 32'hA5A5_A5A5; REQ0_VALID = 1'b1;
    wait_ready(who);
    check32("t1_winner", 32'(who), 32'd0);
    push_exp(1'b0, 32'h0000_0010, 32'hA5A5_A5A5);
    @(negedge ACLK);
    REQ0_VALID = 1'b0;
    wait_idle();
    @(negedge ACLK); #1;
    check32("t1_starts", 32'(n_starts - s0), 32'd1);
    check32("t1_dones", 32'(n_dones - d0), 32'd1);
    check1("t1_grant", GRANT, 1'b0);

    // Both requesters held valid after reset: grants alternate 0,1,0,1.
    reset_pulse();
    run_len = 2;
    s0 = n_starts; d0 = n_dones;
    REQ0_ADDR = 32'h0000_0100; REQ0_DATA = 32'h1111_1111;
    REQ1_ADDR = 32'h0000_0200; REQ1_DATA = 32'h2222_2222;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ready(who);
      check32("t2_rr_order", 32'(who), 32'(k % 2));
      if (k % 2 == 0) push_exp(1'b0, 32'h0000_0100, 32'h1111_1111);
      else            push_exp(1'b1, 32'h0000_0200, 32'h2222_2222);
      @(negedge ACLK);
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    wait_idle();
    @(negedge ACLK); #1;
    check32("t2_starts", 32'(n_starts - s0), 32'd4);
    check32("t2_dones", 32'(n_dones - d0), 32'd4);

    // Back-to-back from requester 1: each word accepted in the DONE cycle.
    run_len = 3;
    s0 = n_starts; d0 = n_dones;
    REQ1_ADDR = 32'h0000_0300; REQ1_DATA = 32'hC0DE_0000; REQ1_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ready(who);
      check32("t3_winner", 32'(who), 32'd1);
      if (k > 0) check1("t3_accept_in_done", REQ1_DONE, 1'b1);
      push_exp(1'b1, 32'h0000_0300 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
      @(negedge ACLK);
      if (k < 2) begin
        REQ1_ADDR = 32'h0000_0300 + 32'(4 * (k + 1));
        REQ1_DATA = 32'hC0DE_0000 + 32'(k + 1);
      end else begin
        REQ1_VALID = 1'b0;
      end
    end
    wait_idle();
    @(negedge ACLK); #1;
    check32("t3_starts", 32'(n_starts - s0), 32'd3);
    check32("t3_dones", 32'(n_dones - d0), 32'd3);
    check32("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Timeout: writer never runs, DONE after TO wait cycles.
    run_len = 0;
    REQ0_ADDR = 32'h0000_0400; REQ0_DATA = 32'hDEAD_0004; REQ0_VALID = 1'b1;
    wait_ready(who);
    push_exp(1'b0, 32'h0000_0400, 32'hDEAD_0004);
    count_to_done(cyc);
    check32("t4_done_latency", 32'(cyc), 32'(TO + 2));
    check1("t4_err_set", TIMEOUT_ERR, 1'b1);
    repeat (3) @(negedge ACLK);
    #1;
    check1("t4_err_sticky", TIMEOUT_ERR, 1'b1);
    ERR_CLR = 1'b1;
    @(negedge ACLK);
    ERR_CLR = 1'b0;
    #1;
    check1("t4_err_cleared", TIMEOUT_ERR, 1'b0);

    // Run falls in the limit cycle: normal completion, no error.
    run_len = TO - 1;
    @(negedge ACLK);
    REQ0_ADDR = 32'h0000_0500; REQ0_DATA = 32'h0000_0505; REQ0_VALID = 1'b1;
    wait_ready(who);
    push_exp(1'b0, 32'h0000_0500, 32'h0000_0505);
    count_to_done(cyc);
    check32("t6_collide_latency", 32'(cyc), 32'(TO + 2));
    check1("t6_collide_no_err", TIMEOUT_ERR, 1'b0);

    // Run still high at the limit, with ERR_CLR held: the set wins.
    run_len = TO;
    @(negedge ACLK);
    ERR_CLR = 1'b1;
    REQ0_ADDR = 32'h0000_0510; REQ0_DATA = 32'h0000_0515; REQ0_VALID = 1'b1;
    wait_ready(who);
    push_exp(1'b0, 32'h0000_0510, 32'h0000_0515);
    count_to_done(cyc);
    check32("t6_limit_latency", 32'(cyc), 32'(TO + 2));
    check1("t6_set_beats_clr", TIMEOUT_ERR, 1'b1);
    @(negedge ACLK); #1;
    check1("t6_clr_after_set", TIMEOUT_ERR, 1'b0);
    ERR_CLR = 1'b0;

    // Reset during WAIT_DONE aborts the transfer without DONE.
    run_len = 10;
    @(negedge ACLK);
    REQ1_ADDR = 32'h0000_0600; REQ1_DATA = 32'h0000_0606; REQ1_VALID = 1'b1;
    wait_ready(who);
    push_exp(1'b1, 32'h0000_0600, 32'h0000_0606);
    @(negedge ACLK);
    REQ1_VALID = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    check1("t5_busy_before_rst", BUSY, 1'b1);
    ARESETn = 1'b0;
    done_q.delete();
    #1;
    check1("t5_rst_busy", BUSY, 1'b0);
    check1("t5_rst_grant", GRANT, 1'b1);
    check32("t5_rst_write_to", Write_to, 32'd0);
    check32("t5_rst_w_data", W_Data, 32'd0);
    check1("t5_rst_w_start", W_Start, 1'b0);
    s0 = n_starts; d0 = n_dones;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (4) @(negedge ACLK);
    #1;
    check32("t5_no_start", 32'(n_starts - s0), 32'd0);
    check32("t5_no_done", 32'(n_dones - d0), 32'd0);
    run_len = 2;
    @(negedge ACLK);
    REQ0_ADDR = 32'h0000_0700; REQ0_DATA = 32'h0000_0707; REQ0_VALID = 1'b1;
    wait_ready(who);
    check32("t5_new_winner", 32'(who), 32'd0);
    push_exp(1'b0, 32'h0000_0700, 32'h0000_0707);
    @(negedge ACLK);
    REQ0_VALID = 1'b0;
    wait_idle();
    @(negedge ACLK); #1;
    check32("t5_new_starts", 32'(n_starts - s0), 32'd1);
    check32("t5_new_dones", 32'(n_dones - d0), 32'd1);

    check32("final_sb_empty", 32'(exp_q.size()), 32'd0);
    check32("final_done_empty", 32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
